rr_mux_8to1_16b: RTL



---
 rtl/alu_mux_pkg.sv | 20 ++
 rtl/rr_pick_8.sv | 44 ++++
 rtl/rr_mux_8to1_16b.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_mux_pkg.sv
// ---------------------------------------------------------------------------
// alu_mux_pkg
// Shared constants and types for the ALU result-return collector.
//   NUM_CH      : number of producer lanes (fixed at 8)
//   W           : data width of one lane word
//   SEL_W       : width of a lane index
//   out_state_t : occupancy of the single output register
// ---------------------------------------------------------------------------
package alu_mux_pkg;

    localparam int NUM_CH = 8;
    localparam int W      = 16;
    localparam int SEL_W  = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage : alu_mux_pkg

// File: rtl/rr_pick_8.sv
// ---------------------------------------------------------------------------
// rr_pick_8
// Purely combinational round-robin picker over eight requesters. The search
// starts at ptr+1 and wraps, so the lane last served has lowest priority.
// Ports:
//   i_req     [7:0] : request vector
//   i_ptr     [2:0] : index of the lane that won most recently
//   o_gnt     [7:0] : one-hot grant, zero when no request
//   o_gnt_idx [2:0] : binary index of the granted lane (0 when none)
//   o_any           : at least one request present
// ---------------------------------------------------------------------------
module rr_pick_8
    import alu_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [SEL_W-1:0]  o_gnt_idx,
    output logic              o_any
);

    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        // Offsets 1..8; offset 8 wraps back to ptr itself, which is the
        // last candidate considered.
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = i_ptr + SEL_W'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found          = 1'b1;
                o_gnt[w_idx]     = 1'b1;
                o_gnt_idx        = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule : rr_pick_8

// File: rtl/rr_mux_8to1_16b.sv
// ---------------------------------------------------------------------------
// rr_mux_8to1_16b
// Round-robin 8-to-1 collector for 16-bit words. Eight producer lanes offer
// words under valid/ready; one word per cycle is forwarded into a single
// registered output stage tagged with its source lane.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_in_valid   [7:0]   : per-lane word present
//   i_in_data    [127:0] : lane i at bits [16i+15:16i]
//   o_in_ready   [7:0]   : per-lane accept, one-hot or zero
//   o_out_valid          : output register holds a word
//   o_out_data   [15:0]  : forwarded word
//   o_out_sel    [2:0]   : lane that supplied o_out_data
//   i_out_ready          : consumer accepts the output word
// ---------------------------------------------------------------------------
module rr_mux_8to1_16b
    import alu_mux_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_CH-1:0]   i_in_valid,
    input  logic [NUM_CH*W-1:0] i_in_data,
    output logic [NUM_CH-1:0]   o_in_ready,
    output logic                o_out_valid,
    output logic [W-1:0]        o_out_data,
    output logic [SEL_W-1:0]    o_out_sel,
    input  logic                i_out_ready
);

    out_state_t       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [W-1:0]     r_data;
    logic [SEL_W-1:0] r_sel;

    logic [NUM_CH-1:0] w_gnt;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic              w_any;
    logic              w_load;
    logic              w_xfer;
    logic [W-1:0]      w_sel_data;

    rr_pick_8 u_pick (
        .i_req     (i_in_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // The register can take a word when empty, or when its current word is
    // leaving on this same edge.
    assign w_load = (r_state == EMPTY) || i_out_ready;

    // Gating with i_rst_n keeps producers from seeing an accept while reset
    // is held, so no handshake can complete on a reset edge.
    assign o_in_ready = (w_load && i_rst_n) ? w_gnt : '0;
    assign w_xfer     = w_load && w_any;

    assign w_sel_data = i_in_data[w_gnt_idx*W +: W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= SEL_W'(NUM_CH - 1);
            r_data  <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_xfer) begin
                        r_state <= FULL;
                        r_data  <= w_sel_data;
                        r_sel   <= w_gnt_idx;
                        r_ptr   <= w_gnt_idx;
                    end
                end
                FULL: begin
                    if (i_out_ready) begin
                        if (w_xfer) begin
                            r_data <= w_sel_data;
                            r_sel  <= w_gnt_idx;
                            r_ptr  <= w_gnt_idx;
                        end else begin
                            r_state <= EMPTY;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign o_out_valid = (r_state == FULL);
    assign o_out_data  = r_data;
    assign o_out_sel   = r_sel;

endmodule : rr_mux_8to1_16b
